// File: rtl/x_play_sched.sv
// x_play_sched: sample playback scheduler sharing one memory port with a host, playback wins only in FETCH.
module x_play_sched #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 6,
  parameter int DIV_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_loop,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_gnt,
  output logic              o_host_rvalid,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_bin,
  output logic              o_busy,
  output logic              o_done
);
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [DIV_W-1:0] cnt;
  logic hit, last;
  assign hit  = state == HOLD && cnt == i_div;
  assign last = ptr == i_end_addr;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      o_bin         <= '0;
      o_done        <= 1'b0;
      o_host_rvalid <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= state == HOLD ? cnt + 1'b1 : '0;
      o_done        <= hit && i_en && last && !i_loop;
      o_host_rvalid <= o_host_gnt && !i_host_we;
      if (state == IDLE && i_en) ptr <= i_start_addr;
      if (hit && i_en) ptr <= last ? (i_loop ? i_start_addr : ptr) : ptr + 1'b1;
      if (state == CAPTURE && i_en) o_bin <= i_mem_rdata;
    end
  end
  // Dropping enable wins over every transition, so an in-flight capture is discarded.
  always_comb begin
    state_n = !i_en            ? IDLE :
              state == IDLE    ? FETCH :
              state == FETCH   ? CAPTURE :
              state == CAPTURE ? HOLD :
              !hit             ? HOLD :
              last && !i_loop  ? IDLE : FETCH;
  end
  always_comb begin
    o_busy       = state != IDLE;
    o_host_gnt   = i_host_req && state != FETCH;
    o_mem_addr   = state == FETCH ? ptr : i_host_addr;
    o_mem_we     = o_host_gnt && i_host_we;
    o_mem_wdata  = i_host_wdata;
    o_host_rdata = i_mem_rdata;
  end
endmodule

// File: doc/x_play_sched.md
X_PLAY_SCHED -- requirements
Module: x_play_sched

Interface
REQ-001 SHALL have exactly one clock and one reset: one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameters: ADDR_W, default 11, memory address width. DATA_W, default 6, sample width. DIV_W, default 16, rate divider width.
REQ-003 SHALL have ports:
  i_clk  in  1  clock
  i_rst  in  1  async active-high reset
  i_en  in  1  playback enable, level
  i_loop  in  1  1 = wrap to start at end, 0 = one-shot
  i_div  in  DIV_W  sample period minus 1, in cycles
  i_start_addr  in  ADDR_W  first sample address
  i_end_addr  in  ADDR_W  last sample address, inclusive
  i_host_req  in  1  host requests memory this cycle
  i_host_we  in  1  host write qualifier
  i_host_addr  in  ADDR_W  host address
  i_host_wdata  in  DATA_W  host write data
  o_host_gnt  out  1  host access performed this cycle
  o_host_rvalid  out  1  host read data valid
  o_host_rdata  out  DATA_W  host read data
  o_mem_addr  out  ADDR_W  memory address
  o_mem_we  out  1  memory write enable
  o_mem_wdata  out  DATA_W  memory write data
  i_mem_rdata  in  DATA_W  memory read data, 1-cycle registered latency
  o_bin  out  DATA_W  current DAC sample to binary-to-thermometer stage
  o_busy  out  1  playback active
  o_done  out  1  one-cycle pulse, one-shot playback complete

Function
REQ-004 SHALL implement states IDLE, FETCH, CAPTURE, HOLD.
REQ-005 IDLE: on i_en=1, SHALL load play pointer with i_start_addr and enter FETCH next cycle.
REQ-006 FETCH: SHALL drive o_mem_addr=pointer, o_mem_we=0, o_host_gnt=0; next state CAPTURE.
REQ-007 CAPTURE: SHALL register i_mem_rdata into o_bin (visible 2 cycles after FETCH), clear divider counter, enter HOLD.
REQ-008 HOLD: divider SHALL count up each cycle; when counter equals i_div, SHALL advance pointer and enter FETCH; FETCH-to-FETCH period SHALL be exactly i_div+3 cycles (i_div+1 HOLD cycles, plus FETCH and CAPTURE).
REQ-009 Pointer advance SHALL be +1 modulo 2^ADDR_W; if pointer equals i_end_addr before advance: i_loop=1 -> load i_start_addr; i_loop=0 -> pulse o_done, enter IDLE, no further fetch.
REQ-010 i_start_addr > i_end_addr SHALL be legal: playback wraps through address 2^ADDR_W-1 to 0.
REQ-011 i_start_addr == i_end_addr SHALL play one sample (one-shot) or repeat it (loop).
REQ-012 Arbitration: playback SHALL have fixed priority in FETCH; in all other states i_host_req SHALL be granted same cycle (o_host_gnt=1) with o_mem_addr/we/wdata driven combinationally from host inputs.
REQ-013 Denied host request SHALL NOT be queued; host holds request until o_host_gnt=1.
REQ-014 Granted host read SHALL assert o_host_rvalid one cycle later with o_host_rdata=i_mem_rdata; o_host_rdata SHALL be i_mem_rdata in all cycles.
REQ-015 Host write to the address currently being played SHALL be permitted; the new value takes effect at that address's next fetch.
REQ-016 o_mem_we SHALL be 0 whenever o_host_gnt=0.
REQ-017 i_en=0 in any non-IDLE state SHALL return to IDLE next cycle; an in-flight CAPTURE SHALL be discarded; o_bin holds; o_done SHALL NOT pulse.
REQ-018 i_div, i_start_addr, i_end_addr, i_loop SHALL be sampled live; changes mid-playback take effect at the next compare.
REQ-019 o_busy SHALL be 1 in every non-IDLE state.
REQ-020 o_done and i_en=1 in same cycle with i_loop=0: block SHALL stay IDLE for one cycle, then restart from i_start_addr.

Reset
REQ-021 On i_rst=1: state IDLE, pointer 0, divider 0, o_bin 0, o_busy 0, o_done 0, o_host_rvalid 0; o_host_gnt follows i_host_req.
REQ-022 Reset asserted mid-playback SHALL abort immediately with no o_done pulse.

Verification
REQ-023 One-shot: mem[10..12]=5,6,7, start=10, end=12, div=2, loop=0 -> o_bin 5,6,7 spaced 5 cycles, o_done one pulse, o_bin stays 7.
REQ-024 Loop wrap: start=2046, end=1, div=0, loop=1 -> addresses 2046,2047,0,1,2046... every 3 cycles.
REQ-025 Contention: host read asserted every cycle during playback -> o_host_gnt=0 exactly in FETCH cycles, rvalid data matches memory.
REQ-026 Abort: drop i_en in CAPTURE -> IDLE next cycle, o_bin unchanged, no o_done.
REQ-027 Live update: host writes 63 to playing address in loop mode -> o_bin shows 63 on next pass.
REQ-028 Reset mid-HOLD -> all outputs at reset values same cycle (async).
